// File: rtl/keycode_event_gen.sv
// Debounces a level-held keycode into one-Clk press events with auto-repeat.
// All key timing is counted in frame ticks recovered from the asynchronous frame clock.
module keycode_event_gen #(
    parameter int DEBOUNCE_FRAMES = 2,
    parameter int REPEAT_DELAY    = 30,
    parameter int REPEAT_RATE     = 6
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode_raw,
    output logic       key_event,
    output logic [7:0] event_code,
    output logic       held
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        REPEAT   = 2'd3
    } state_t;

    localparam logic [7:0] DEB_TARGET   = 8'(DEBOUNCE_FRAMES);
    localparam logic [7:0] DELAY_TARGET = 8'(REPEAT_DELAY);
    localparam logic [7:0] RATE_TARGET  = 8'(REPEAT_RATE);
    localparam bit         DEB_ONE      = (DEBOUNCE_FRAMES == 1);
    localparam bit         REPEAT_ON    = (REPEAT_RATE != 0);

    logic       sync1_r, sync2_r, sync3_r, tick_r;
    state_t     state_r, state_s;
    logic [7:0] cand_r, cand_s;
    logic [7:0] cnt_r, cnt_s, cnt_inc_s;
    logic       emit_s;
    logic       key_event_r, held_r;
    logic [7:0] event_code_r;

    assign cnt_inc_s  = cnt_r + 8'd1;
    assign key_event  = key_event_r;
    assign event_code = event_code_r;
    assign held       = held_r;

    // Frame clock synchronizer and single-cycle rising-edge tick.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            sync3_r <= 1'b0;
            tick_r  <= 1'b0;
        end else begin
            sync1_r <= frame_clk;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
            tick_r  <= sync2_r & ~sync3_r;
        end
    end

    // Next-state, candidate and counter decisions, evaluated only on frame ticks.
    always_comb begin
        state_s = state_r;
        cand_s  = cand_r;
        cnt_s   = cnt_r;
        emit_s  = 1'b0;
        if (tick_r) begin
            if (keycode_raw == 8'h00) begin
                state_s = IDLE;
                cnt_s   = 8'd0;
            end else if ((state_r == IDLE) || (keycode_raw != cand_r)) begin
                // Fresh press or rollover to a different key restarts debounce.
                cand_s = keycode_raw;
                if (DEB_ONE) begin
                    emit_s  = 1'b1;
                    state_s = HELD;
                    cnt_s   = 8'd0;
                end else begin
                    state_s = DEBOUNCE;
                    cnt_s   = 8'd1;
                end
            end else begin
                case (state_r)
                    DEBOUNCE: begin
                        if (cnt_inc_s == DEB_TARGET) begin
                            emit_s  = 1'b1;
                            state_s = HELD;
                            cnt_s   = 8'd0;
                        end else begin
                            cnt_s = cnt_inc_s;
                        end
                    end
                    HELD: begin
                        if (REPEAT_ON) begin
                            if (cnt_inc_s == DELAY_TARGET) begin
                                emit_s  = 1'b1;
                                state_s = REPEAT;
                                cnt_s   = 8'd0;
                            end else begin
                                cnt_s = cnt_inc_s;
                            end
                        end else if (cnt_r < DELAY_TARGET) begin
                            cnt_s = cnt_inc_s;
                        end else begin
                            cnt_s = cnt_r;
                        end
                    end
                    REPEAT: begin
                        if (cnt_inc_s == RATE_TARGET) begin
                            emit_s = 1'b1;
                            cnt_s  = 8'd0;
                        end else begin
                            cnt_s = cnt_inc_s;
                        end
                    end
                    default: begin
                        state_s = IDLE;
                        cnt_s   = 8'd0;
                    end
                endcase
            end
        end else begin
            state_s = state_r;
        end
    end

    // State, counter and registered output update.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r      <= IDLE;
            cand_r       <= 8'h00;
            cnt_r        <= 8'd0;
            key_event_r  <= 1'b0;
            event_code_r <= 8'h00;
            held_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            cand_r      <= cand_s;
            cnt_r       <= cnt_s;
            key_event_r <= emit_s;
            held_r      <= (state_s == HELD) || (state_s == REPEAT);
            if (emit_s) begin
                event_code_r <= cand_s;
            end else begin
                event_code_r <= event_code_r;
            end
        end
    end

endmodule

// File: tb/tb_keycode_event_gen.sv
// Randomized and directed bench for keycode_event_gen against a run-length key model.
// Three parameter sets share one stimulus stream.
module tb_keycode_event_gen;

    localparam int NDUT = 3;

    logic             Clk = 1'b0;
    logic             Reset;
    logic             frame_clk;
    logic [7:0]       keycode_raw;
    logic [NDUT-1:0]  obs_ev;
    logic [7:0]       obs_code [NDUT];
    logic [NDUT-1:0]  obs_held;

    int df_p   [NDUT] = '{2, 1, 3};
    int rd_p   [NDUT] = '{30, 3, 2};
    int rate_p [NDUT] = '{6, 0, 1};

    logic [NDUT-1:0]  exp_ev, nxt_ev;
    logic [7:0]       exp_code [NDUT];
    logic [7:0]       nxt_code [NDUT];
    logic [NDUT-1:0]  exp_held, nxt_held;

    logic [7:0] run_key;
    int         run_len;
    int         n_checks, n_fail;
    bit         check_en;
    int         frame_no;
    int         ev_frames[$];
    int         b_events;
    int         t3_exp [5] = '{2, 32, 38, 44, 50};

    always #5 Clk = ~Clk;

    keycode_event_gen #(.DEBOUNCE_FRAMES(2), .REPEAT_DELAY(30), .REPEAT_RATE(6)) dut_a (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode_raw(keycode_raw),
        .key_event(obs_ev[0]), .event_code(obs_code[0]), .held(obs_held[0]));
    keycode_event_gen #(.DEBOUNCE_FRAMES(1), .REPEAT_DELAY(3), .REPEAT_RATE(0)) dut_b (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode_raw(keycode_raw),
        .key_event(obs_ev[1]), .event_code(obs_code[1]), .held(obs_held[1]));
    keycode_event_gen #(.DEBOUNCE_FRAMES(3), .REPEAT_DELAY(2), .REPEAT_RATE(1)) dut_c (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode_raw(keycode_raw),
        .key_event(obs_ev[2]), .event_code(obs_code[2]), .held(obs_held[2]));

    task automatic check8(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d frame %0d: got %h, expected %h", name, idx, frame_no, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Event on run length n: first at the debounce length, then delay, then every rate ticks.
    function automatic bit is_event(input int i, input int n);
        if (n == 0) return 1'b0;
        if (n == df_p[i]) return 1'b1;
        if (rate_p[i] == 0) return 1'b0;
        if (n < df_p[i] + rd_p[i]) return 1'b0;
        return ((n - df_p[i] - rd_p[i]) % rate_p[i]) == 0;
    endfunction

    task automatic model_reset();
        run_key = 8'h00;
        run_len = 0;
        for (int i = 0; i < NDUT; i++) begin
            exp_ev[i] = 1'b0; exp_code[i] = 8'h00; exp_held[i] = 1'b0;
            nxt_ev[i] = 1'b0; nxt_code[i] = 8'h00; nxt_held[i] = 1'b0;
        end
    endtask

    task automatic model_step(input logic [7:0] k);
        if (k == 8'h00) begin
            run_len = 0;
        end else if ((k == run_key) && (run_len > 0)) begin
            run_len++;
        end else begin
            run_key = k;
            run_len = 1;
        end
        for (int i = 0; i < NDUT; i++) begin
            nxt_ev[i]   = is_event(i, run_len);
            nxt_held[i] = (run_len > 0) && (run_len >= df_p[i]);
            if (nxt_ev[i]) nxt_code[i] = run_key;
        end
    endtask

    // One frame: raise frame_clk, expect the result on the 4th Clk edge, optional reset in that pulse.
    task automatic do_frame(input logic [7:0] k, input bit rst_pulse);
        frame_no++;
        @(negedge Clk);
        keycode_raw = k;
        frame_clk   = 1'b1;
        model_step(k);
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        frame_clk = 1'b0;
        @(posedge Clk);
        #1;
        exp_ev = nxt_ev;
        exp_held = nxt_held;
        for (int i = 0; i < NDUT; i++) exp_code[i] = nxt_code[i];
        if (rst_pulse) begin
            for (int i = 0; i < NDUT; i++) check8("pre_reset_event", i, {7'd0, obs_ev[i]}, {7'd0, exp_ev[i]});
            #1;
            Reset = 1'b1;
            #1;
            model_reset();
            for (int i = 0; i < NDUT; i++) begin
                check8("reset_event_drop", i, {7'd0, obs_ev[i]}, 8'h00);
                check8("reset_held_drop", i, {7'd0, obs_held[i]}, 8'h00);
                check8("reset_code_clear", i, obs_code[i], 8'h00);
            end
            repeat (2) @(negedge Clk);
            Reset = 1'b0;
        end else begin
            @(posedge Clk);
            #1;
            exp_ev = '0;
        end
        repeat ($urandom_range(2, 6)) @(negedge Clk);
    endtask

    task automatic new_scenario();
        frame_no = 0;
        ev_frames.delete();
        b_events = 0;
    endtask

    initial begin
        logic [7:0] cur;
        n_checks = 0; n_fail = 0; check_en = 1'b0; frame_no = 0; b_events = 0;
        Reset = 1'b1; frame_clk = 1'b0; keycode_raw = 8'h00;
        model_reset();
        fork
            begin
                forever begin
                    @(negedge Clk);
                    if (check_en) begin
                        for (int i = 0; i < NDUT; i++) begin
                            check8("key_event", i, {7'd0, obs_ev[i]}, {7'd0, exp_ev[i]});
                            check8("event_code", i, obs_code[i], exp_code[i]);
                            check8("held", i, {7'd0, obs_held[i]}, {7'd0, exp_held[i]});
                        end
                        if (obs_ev[0] === 1'b1) ev_frames.push_back(frame_no);
                        if (obs_ev[1] === 1'b1) b_events++;
                    end
                end
            end
            begin
                repeat (3) @(negedge Clk);
                check_en = 1'b1;
                @(negedge Clk);
                Reset = 1'b0;

                new_scenario();
                for (int f = 0; f < 10; f++) do_frame(8'h00, 1'b0);
                check_int("t1_event_count", ev_frames.size(), 0);

                new_scenario();
                for (int f = 0; f < 5; f++) do_frame(8'h52, 1'b0);
                check8("t2_held_at_5", 0, {7'd0, obs_held[0]}, 8'h01);
                do_frame(8'h00, 1'b0);
                check_int("t2_event_count", ev_frames.size(), 1);
                if (ev_frames.size() > 0) check_int("t2_event_tick", ev_frames[0], 2);
                check8("t2_event_code", 0, obs_code[0], 8'h52);
                check8("t2_held_after", 0, {7'd0, obs_held[0]}, 8'h00);

                new_scenario();
                for (int f = 0; f < 50; f++) do_frame(8'h51, 1'b0);
                check_int("t3_event_count", ev_frames.size(), 5);
                for (int j = 0; j < 5; j++)
                    if (j < ev_frames.size()) check_int("t3_event_tick", ev_frames[j], t3_exp[j]);
                check8("t3_event_code", 0, obs_code[0], 8'h51);
                check_int("t3_norepeat_count", b_events, 1);
                do_frame(8'h00, 1'b0);

                new_scenario();
                do_frame(8'h58, 1'b0);
                do_frame(8'h00, 1'b0);
                check_int("t4_event_count", ev_frames.size(), 0);
                check8("t4_held", 0, {7'd0, obs_held[0]}, 8'h00);

                new_scenario();
                for (int f = 0; f < 4; f++) do_frame(8'h51, 1'b0);
                for (int f = 0; f < 3; f++) do_frame(8'h52, 1'b0);
                check_int("t5_event_count", ev_frames.size(), 2);
                if (ev_frames.size() > 1) begin
                    check_int("t5_first_tick", ev_frames[0], 2);
                    check_int("t5_second_tick", ev_frames[1], 6);
                end
                check8("t5_event_code", 0, obs_code[0], 8'h52);
                do_frame(8'h00, 1'b0);

                new_scenario();
                for (int f = 1; f <= 20; f++) do_frame(8'h51, f == 20);
                check_int("t6_norepeat_count", b_events, 1);
                new_scenario();
                for (int f = 0; f < 3; f++) do_frame(8'h51, 1'b0);
                check_int("t6_after_reset_count", ev_frames.size(), 1);
                if (ev_frames.size() > 0) check_int("t6_after_reset_tick", ev_frames[0], 2);
                do_frame(8'h00, 1'b0);

                new_scenario();
                do_frame(8'h33, 1'b0);
                do_frame(8'h33, 1'b1);
                do_frame(8'h00, 1'b0);

                cur = 8'h00;
                for (int f = 0; f < 400; f++) begin
                    int r;
                    r = $urandom_range(0, 99);
                    if (r < 80) begin
                        cur = cur;
                    end else if (r < 90) begin
                        cur = 8'h00;
                    end else begin
                        case ($urandom_range(0, 3))
                            0: cur = 8'h11;
                            1: cur = 8'h22;
                            2: cur = 8'h33;
                            default: cur = 8'($urandom_range(1, 255));
                        endcase
                    end
                    do_frame(cur, $urandom_range(0, 99) < 2);
                end
                do_frame(8'h00, 1'b0);
            end
        join_any
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
